gcd_stream: RTL
===============

Name: gcd_stream

Overview:
- Parametrised successor to the fixed 32-bit start/done GCD unit.
- Computes gcd(opa, opb) with the binary (Stein) algorithm, one reduction step per clock.
- Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake with backpressure.
- Also reports the number of compute cycles used, for performance profiling in the arithmetic datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2).
- CNT_W, 8, width of the cycles output; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- opa  input  WIDTH  operand A, sampled on input handshake.
- opb  input  WIDTH  operand B, sampled on input handshake.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  downstream accepts the result.
- result  output  WIDTH  gcd(opa, opb).
- cycles  output  CNT_W  number of CALC cycles taken for this result.
- busy  output  1  high while in CALC.

Behaviour:
- Reset (reset==0, async): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; cycles=0; internal a, b, k cleared.
- States and transitions:
  - IDLE: in_ready=1. Input handshake (in_valid & in_ready) at an edge loads a=opa, b=opb, k=0, cnt=0, then goes to CALC.
  - CALC: in_ready=0, busy=1. At each edge cnt increments (saturating), and exactly one action is taken, in priority order:
    1. a==0: result=b<<k, go to DONE.
    2. b==0: result=a<<k, go to DONE.
    3. a and b both even: a>>=1, b>>=1, k++.
    4. a even: a>>=1.
    5. b even: b>>=1.
    6. Both odd, a>=b: a=(a-b)>>1.
    7. Both odd, a<b: b=(b-a)>>1.
  - DONE: out_valid=1; result and cycles held stable. Output handshake (out_valid & out_ready) at an edge goes to IDLE, with out_valid=0 after that edge.
- Outputs:
  - cycles equals cnt including the terminating cycle; it is registered on entry to DONE.
  - result and cycles keep their last values in IDLE.
- Latency: out_valid rises N edges after the input-handshake edge, where N = cycles. No back-to-back acceptance: in_ready returns one cycle after the output handshake.
- Width rules:
  - k is clog2(WIDTH)+1 bits.
  - a-b and b-a are computed in WIDTH bits and never underflow because of the ordering rule.
  - The final shift b<<k (or a<<k) cannot overflow WIDTH, since the result is <= max(opa, opb).
- Boundaries:
  - gcd(0,0)=0 in 1 cycle.
  - gcd(x,0)=x and gcd(0,x)=x.
  - in_valid while not in IDLE is ignored; operands are not captured.
  - opa/opb changes after acceptance have no effect.
  - out_ready low holds DONE indefinitely.
  - Reset asserted mid-CALC or mid-DONE aborts immediately to reset values; the pending result is lost.
  - cnt saturates and never wraps.

Test Plan:
- Reset low for 3 cycles, then high: in_ready=1, out_valid=0, result=0, cycles=0, busy=0.
- opa=1071, opb=462 accepted, out_ready=1 -> out_valid high 9 edges after accept; result=21, cycles=9; in_ready=1 one cycle after the output handshake.
- opa=48, opb=18 -> result=6 (one common-factor-2 shift, k=1), cycles=7. Then opa=0, opb=0 -> result=0, cycles=1. Then opa=0, opb=35 -> result=35, cycles=1.
- WIDTH=32, opa=opb=32'hFFFFFFFF -> result=32'hFFFFFFFF, cycles=2. Repeat with the parameter overridden to WIDTH=8, opa=opb=8'hFF -> result=8'hFF, cycles=2.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises -> result and cycles stable, in_ready=0, and in_valid pulses with new operands are ignored. Release out_ready -> one handshake, no duplicate out_valid.
- Abort: accept 1071/462, drive reset=0 on the 4th CALC cycle -> outputs go to reset values immediately. After reset release, accept 48/18 -> result=6, cycles=7.

Source files
------------

// File: rtl/gcd_stream.sv
// Streaming binary (Stein) GCD: one reduction step per clock, valid/ready on both sides,
// plus a saturating count of the compute cycles spent on each result.
module gcd_stream #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] cycles,
    output logic             busy
);

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturate rather than wrap so very long runs still report a sane upper bound.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cycles_d = cycles_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = opa;
                    b_d     = opb;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                cnt_d = cnt_inc;
                if (a_q == '0) begin
                    result_d = b_q << k_q;
                    cycles_d = cnt_inc;
                    state_d  = StDone;
                end else if (b_q == '0) begin
                    result_d = a_q << k_q;
                    cycles_d = cnt_inc;
                    state_d  = StDone;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + KW'(1);
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cycles_q <= cycles_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StCalc);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign cycles    = cycles_q;

endmodule
